crc_rx_checker: RTL
===================

// Module: crc_rx_checker
// PURPOSE
//  Receive-side counterpart of the transmit CRC generator. Sits between the bit
//  unstuffer and the protocol handler and deserialises one packet's bits into a
//  buffer (PID included). It validates the PID check nibble, runs CRC5 (token/SOF)
//  or CRC16 (data) over the post-PID bits, and presents the packet with status flags.
// PARAMETERS
//  MAX_BITS  100  packet buffer width in bits; longer packets flag overflow
// PORTS
//  clock      in   1         system clock
//  reset      in   1         synchronous, active-high reset
//  in_bit     in   1         received bit, LSB-first, from unstuffer
//  in_valid   in   1         in_bit valid this cycle; ignored unless rx_ready
//  in_eop     in   1         end of packet; may coincide with the final in_valid
//  rx_ready   out  1         block can accept bits/eop (low while holding result)
//  pkt_out    out  MAX_BITS  received bits; bit i = i-th bit received, rest 0
//  pkt_len    out  32        number of bits received (saturates at MAX_BITS+1)
//  pkt_valid  out  1         result held; stays high until pkt_ack
//  pid_ok     out  1         PID[7:4] == ~PID[3:0] and >=8 bits received
//  crc_ok     out  1         residue/length check passed (see BEHAVIOUR)
//  overflow   out  1         more than MAX_BITS bits received
//  pkt_ack    in   1         PH consumed result; frees the block
// BEHAVIOUR
//  Reset: all outputs 0 except rx_ready=1; state IDLE; bit count 0; crc reg all 1s.
//  FSM: IDLE -first accepted bit-> PID; PID -8th bit-> BODY; PID/BODY -in_eop-> DONE;
//   DONE -pkt_ack-> IDLE. in_eop in IDLE (no bits) is ignored.
//  Accept = in_valid & rx_ready. Accepted bit stored at pkt_out[cnt] if cnt<MAX_BITS;
//   cnt++ saturating at MAX_BITS+1; overflow set once cnt would exceed MAX_BITS.
//  in_valid and in_eop in the same cycle: the bit is accepted first, then eop closes.
//  PID = bits 0..7. Mode from PID[1:0]: 01 -> CRC5, 11 -> CRC16, 10 -> none, 00 -> none.
//  CRC update applies only to bits 8 onward. Per bit b: fb=b^c[W-1];
//   c={c[W-2:0],1'b0} ^ (fb ? POLY : 0). POLY5=5'b00101, POLY16=16'h8005; preset all 1s.
//   Both CRC registers run in parallel; the mode selects which result is used.
//  On eop (entering DONE): pkt_valid=1, rx_ready=0, outputs frozen until pkt_ack.
//   CRC5 mode:  crc_ok = (c5==5'b01100) & (len==24) & ~overflow.
//   CRC16 mode: crc_ok = (c16==16'h800D) & (len>=24) & ((len-8)%8==0) & ~overflow.
//   none mode:  crc_ok = (len==8).   len<8: pid_ok=0, crc_ok=0.
//  Result latency: flags valid the cycle after the eop cycle (registered).
//  While DONE: in_valid/in_eop ignored (upstream must obey rx_ready).
//  pkt_ack outside DONE: ignored. pkt_ack in DONE: next cycle IDLE, pkt_valid=0,
//   rx_ready=1, pkt_out cleared, cnt=0, CRC regs preset; a bit may be taken that cycle.
//  Reset mid-packet: immediate return to reset state; partial packet discarded.
// TESTING
//  OUT token: bits of 24'h8205E1 LSB-first, eop on bit 24 -> pkt_valid, pkt_len=24,
//   pkt_out[23:0]=24'h8205E1, pid_ok=1, crc_ok=1, overflow=0.
//  Same token with bit 9 flipped -> pid_ok=1, crc_ok=0.
//  ACK (8'hD2, 8 bits) -> pkt_len=8, pid_ok=1, crc_ok=1; 8'hD3 -> pid_ok=0.
//  DATA0 empty: 8'hC3 then 16 zero bits -> pkt_len=24, crc_ok=1; flip last bit -> crc_ok=0.
//  101 bits then eop -> overflow=1, crc_ok=0, pkt_len=101; bits held until pkt_ack.
//  pkt_valid held 5 cycles with in_valid=1 -> no state change; reset mid-token -> IDLE.

Source files
------------

// File: rtl/crc_rx_checker_if.sv
// Bit-stream and result bundle between the unstuffer, the CRC receive checker
// and the protocol handler. master = upstream/PH side, slave = checker.
interface crc_rx_checker_if #(
    parameter int MAX_BITS = 100
);
    logic                in_bit;
    logic                in_valid;
    logic                in_eop;
    logic                rx_ready;
    logic [MAX_BITS-1:0] pkt_out;
    logic [31:0]         pkt_len;
    logic                pkt_valid;
    logic                pid_ok;
    logic                crc_ok;
    logic                overflow;
    logic                pkt_ack;

    modport master (
        output in_bit, in_valid, in_eop, pkt_ack,
        input  rx_ready, pkt_out, pkt_len, pkt_valid, pid_ok, crc_ok, overflow
    );

    modport slave (
        input  in_bit, in_valid, in_eop, pkt_ack,
        output rx_ready, pkt_out, pkt_len, pkt_valid, pid_ok, crc_ok, overflow
    );
endinterface

// File: rtl/crc_rx_checker.sv
// Receive-side CRC checker: deserialises one packet (PID included), checks the
// PID nibble pair, runs CRC5 and CRC16 over the post-PID bits and holds the
// result with status flags until the protocol handler acknowledges it.
//
//  state | meaning
//  IDLE  | waiting for the first bit of a packet
//  PID   | collecting the 8 PID bits
//  BODY  | collecting payload/CRC bits
//  DONE  | result held, input stalled until pkt_ack
module crc_rx_checker #(
    parameter int MAX_BITS = 100
) (
    input logic             clock,
    input logic             reset,
    crc_rx_checker_if.slave bus
);
    localparam int              CW      = $clog2(MAX_BITS + 2);
    localparam logic [CW-1:0]   CNT_SAT = CW'(MAX_BITS + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_BITS);
    localparam logic [4:0]      POLY5   = 5'b00101;
    localparam logic [15:0]     POLY16  = 16'h8005;
    localparam logic [4:0]      RES5    = 5'b01100;
    localparam logic [15:0]     RES16   = 16'h800D;

    typedef enum logic [1:0] {IDLE, PID, BODY, DONE} state_t;

    state_t              state, state_nx;
    logic                rx_ready;
    logic                take;
    logic                close;
    logic [MAX_BITS-1:0] data_q, data_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic                ovf_q, ovf_nx;
    logic [4:0]          c5, c5_nx;
    logic [15:0]         c16, c16_nx;
    logic                fb5, fb16;
    logic                pid_ok_q, crc_ok_q;
    logic                pid_ok_nx, crc_ok_nx;

    assign rx_ready = (state != DONE);
    assign take     = bus.in_valid & rx_ready;
    // eop with nothing received (and no bit this cycle) is ignored
    assign close    = rx_ready & bus.in_eop & (cnt_nx != '0);

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (close)     state_nx = DONE;
                else if (take) state_nx = PID;
            end
            PID: begin
                if (close)                    state_nx = DONE;
                else if (cnt_nx == CW'(8))    state_nx = BODY;
            end
            BODY: begin
                if (close) state_nx = DONE;
            end
            DONE: begin
                if (bus.pkt_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // accumulate the accepted bit: buffer, saturating count, overflow, both CRCs
    always_comb begin
        data_nx = data_q;
        cnt_nx  = cnt;
        ovf_nx  = ovf_q;
        c5_nx   = c5;
        c16_nx  = c16;
        fb5     = 1'b0;
        fb16    = 1'b0;
        if (take) begin
            for (int i = 0; i < MAX_BITS; i++) begin
                if (cnt == CW'(i)) data_nx[i] = bus.in_bit;
            end
            if (cnt != CNT_SAT) cnt_nx = cnt + CW'(1);
            if (cnt >= CNT_MAX) ovf_nx = 1'b1;
            if (cnt >= CW'(8)) begin
                fb5    = bus.in_bit ^ c5[4];
                fb16   = bus.in_bit ^ c16[15];
                c5_nx  = {c5[3:0], 1'b0} ^ (fb5 ? POLY5 : 5'd0);
                c16_nx = {c16[14:0], 1'b0} ^ (fb16 ? POLY16 : 16'd0);
            end
        end
    end

    // status flags evaluated on the values that include a bit coinciding with eop
    always_comb begin
        pid_ok_nx = (cnt_nx >= CW'(8)) && (data_nx[7:4] == ~data_nx[3:0]);
        case (data_nx[1:0])
            2'b01:   crc_ok_nx = (c5_nx == RES5) && (cnt_nx == CW'(24)) && !ovf_nx;
            2'b11:   crc_ok_nx = (c16_nx == RES16) && (cnt_nx >= CW'(24))
                                 && (cnt_nx[2:0] == 3'b000) && !ovf_nx;
            default: crc_ok_nx = (cnt_nx == CW'(8));
        endcase
        if (cnt_nx < CW'(8)) crc_ok_nx = 1'b0;
    end

    // datapath registers: frozen while DONE, cleared on reset or acknowledge
    always_ff @(posedge clock) begin
        if (reset || (state == DONE && bus.pkt_ack)) begin
            data_q   <= '0;
            cnt      <= '0;
            ovf_q    <= 1'b0;
            c5       <= '1;
            c16      <= '1;
            pid_ok_q <= 1'b0;
            crc_ok_q <= 1'b0;
        end else if (state != DONE) begin
            data_q <= data_nx;
            cnt    <= cnt_nx;
            ovf_q  <= ovf_nx;
            c5     <= c5_nx;
            c16    <= c16_nx;
            if (close) begin
                pid_ok_q <= pid_ok_nx;
                crc_ok_q <= crc_ok_nx;
            end
        end
    end

    assign bus.rx_ready  = rx_ready;
    assign bus.pkt_valid = (state == DONE);
    assign bus.pkt_out   = data_q;
    assign bus.pkt_len   = {{(32 - CW){1'b0}}, cnt};
    assign bus.overflow  = ovf_q;
    assign bus.pid_ok    = pid_ok_q;
    assign bus.crc_ok    = crc_ok_q;
endmodule
